// File: rtl/int_requant_pkg.sv
// Shared sizing helpers for the int_requant pipeline.
// Optional saturation counter is enabled by defining INT_REQUANT_SAT_COUNT_EN.
package int_requant_pkg;

    // Signed product width: signed accumulator times zero-extended unsigned scale.
    function automatic int prod_width(input int in_w, input int mult_w);
        return in_w + mult_w + 1;
    endfunction

    // Half-LSB of the shifted result; zero when no shift is applied.
    function automatic logic [63:0] round_const(input int shift);
        logic [63:0] c;
        c = '0;
        if (shift > 0) begin
            c = 64'd1 << (shift - 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/int_requant_lane.sv
// One element of the requantiser: round-half-up, arithmetic shift, saturate.
// The sat flag port exists only when INT_REQUANT_SAT_COUNT_EN is defined.
module int_requant_lane
    import int_requant_pkg::*;
#(
    parameter int PROD_WIDTH = 49,
    parameter int SHIFT      = 16,
    parameter int ACT_WIDTH  = 8
) (
    input  logic signed [PROD_WIDTH-1:0] p,
    output logic        [ACT_WIDTH-1:0]  value
`ifdef INT_REQUANT_SAT_COUNT_EN
    ,
    output logic                         sat
`endif
);

    // One guard bit so the rounding add cannot wrap.
    localparam int SW = PROD_WIDTH + 1;
    localparam logic [SW-1:0]        RND   = SW'(round_const(SHIFT));
    localparam logic signed [SW-1:0] MAX_V = SW'((64'sd1 <<< (ACT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

    logic signed [SW-1:0] r;
    logic signed [SW-1:0] q;
    logic                 sat_hi;
    logic                 sat_lo;

    assign r      = {p[PROD_WIDTH-1], p} + RND;
    assign q      = r >>> SHIFT;
    assign sat_hi = q > MAX_V;
    assign sat_lo = q < MIN_V;

    always_comb begin
        value = q[ACT_WIDTH-1:0];
        if (sat_hi) begin
            value = MAX_V[ACT_WIDTH-1:0];
        end else if (sat_lo) begin
            value = MIN_V[ACT_WIDTH-1:0];
        end
    end

`ifdef INT_REQUANT_SAT_COUNT_EN
    assign sat = sat_hi | sat_lo;
`endif

endmodule

// File: rtl/int_requant.sv
// Two-stage requantiser: S1 multiplies by scale, S2 rounds/shifts/saturates.
// Define INT_REQUANT_SAT_COUNT_EN to add the sat_count/sat_clear ports.
module int_requant
    import int_requant_pkg::*;
#(
    parameter int NUM           = 1,
    parameter int IN_WIDTH      = 32,
    parameter int MULT_WIDTH    = 16,
    parameter int SHIFT         = 16,
    parameter int ACT_WIDTH     = 8,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM*IN_WIDTH-1:0]   in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MULT_WIDTH-1:0]     scale,
    output logic [NUM*ACT_WIDTH-1:0]  out,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef INT_REQUANT_SAT_COUNT_EN
    ,
    output logic [SAT_CNT_WIDTH-1:0]  sat_count,
    input  logic                      sat_clear
`endif
);

    localparam int PW = prod_width(IN_WIDTH, MULT_WIDTH);

    logic                  v1_reg;
    logic                  v2_reg;
    logic                  adv1;
    logic                  adv2;
    logic signed [PW-1:0]  prod_next [NUM];
    logic signed [PW-1:0]  p_reg     [NUM];
    logic [ACT_WIDTH-1:0]  lane_val  [NUM];
    logic [ACT_WIDTH-1:0]  out_reg   [NUM];

    assign adv2      = !v2_reg || out_ready;
    assign adv1      = !v1_reg || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2_reg;

`ifdef INT_REQUANT_SAT_COUNT_EN
    logic [NUM-1:0] lane_sat;
    logic [NUM-1:0] sat_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_lane
            // Scale is zero-extended so it multiplies as unsigned.
            assign prod_next[gi] = PW'($signed(in[gi*IN_WIDTH +: IN_WIDTH]))
                                 * PW'($signed({1'b0, scale}));

            int_requant_lane #(
                .PROD_WIDTH (PW),
                .SHIFT      (SHIFT),
                .ACT_WIDTH  (ACT_WIDTH)
            ) u_lane (
                .p     (p_reg[gi]),
                .value (lane_val[gi])
`ifdef INT_REQUANT_SAT_COUNT_EN
                ,
                .sat   (lane_sat[gi])
`endif
            );

            assign out[gi*ACT_WIDTH +: ACT_WIDTH] = out_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                p_reg[i]   <= '0;
                out_reg[i] <= '0;
            end
        end else begin
            if (adv1) begin
                v1_reg <= in_valid;
                for (int i = 0; i < NUM; i++) begin
                    p_reg[i] <= prod_next[i];
                end
            end
            if (adv2) begin
                v2_reg <= v1_reg;
                for (int i = 0; i < NUM; i++) begin
                    out_reg[i] <= lane_val[i];
                end
            end
        end
    end

`ifdef INT_REQUANT_SAT_COUNT_EN
    logic [SAT_CNT_WIDTH-1:0] sat_count_reg;
    logic [SAT_CNT_WIDTH:0]   sat_sum;

    // Extra top bit of sat_sum flags overflow so the counter sticks at all-ones.
    always_comb begin
        sat_sum = {1'b0, sat_count_reg};
        for (int i = 0; i < NUM; i++) begin
            sat_sum = sat_sum + (SAT_CNT_WIDTH + 1)'(sat_reg[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_reg       <= '0;
            sat_count_reg <= '0;
        end else begin
            if (adv2) begin
                sat_reg <= lane_sat;
            end
            if (sat_clear) begin
                sat_count_reg <= '0;
            end else if (v2_reg && out_ready) begin
                sat_count_reg <= sat_sum[SAT_CNT_WIDTH] ? '1 : sat_sum[SAT_CNT_WIDTH-1:0];
            end
        end
    end

    assign sat_count = sat_count_reg;
`endif

endmodule
